// File: rtl/surf_led_charlieplex.sv
// Charlieplexed LED scanner with a small Wishbone register file.
// Per-LED override, sticky capture and blink; one LED lit per scan slot.
module surf_led_charlieplex #(
  parameter int NPINS      = 4,
  parameter int DWELL      = 16,
  parameter int BLINK_BITS = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [4:0]                   wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  output logic [31:0]                  wb_dat_o,
  output logic                         wb_ack_o,
  input  logic [NPINS*(NPINS-1)-1:0]   internal_led_i,
  output logic [NPINS-1:0]             led_o,
  output logic [NPINS-1:0]             led_oe_o
);
  localparam int NLEDS = NPINS * (NPINS - 1);
  localparam int SW    = $clog2(NLEDS);
  localparam int DW    = $clog2(DWELL);

  logic [NLEDS-1:0]      ovr_en_q, ovr_en_d;
  logic [NLEDS-1:0]      ovr_val_q, ovr_val_d;
  logic [NLEDS-1:0]      blink_en_q, blink_en_d;
  logic [NLEDS-1:0]      sticky_en_q, sticky_en_d;
  logic [NLEDS-1:0]      sticky_q, sticky_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic                  hold_q, hold_d;
  logic [NPINS-1:0]      led_q, led_d;
  logic [NPINS-1:0]      oe_q, oe_d;

  logic                  access, wr, dwell_last;
  logic [NLEDS-1:0]      wdat, clr, eff, disp;
  logic [31:0]           rdat;
  logic [NPINS-1:0]      map_oe, map_led;
  logic                  unused_bits;

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:NLEDS]};

  assign access = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr     = access & wb_we_i;
  assign wdat   = wb_dat_i[NLEDS-1:0];

  assign eff  = (ovr_en_q & ovr_val_q)
              | (~ovr_en_q & sticky_en_q & sticky_q)
              | (~ovr_en_q & ~sticky_en_q & internal_led_i);
  assign disp = eff & (~blink_en_q | {NLEDS{blink_q[BLINK_BITS-1]}});

  always_comb begin
    ovr_en_d    = ovr_en_q;
    ovr_val_d   = ovr_val_q;
    blink_en_d  = blink_en_q;
    sticky_en_d = sticky_en_q;
    clr         = '0;
    if (wr) begin
      unique case (wb_adr_i[4:2])
        3'd0:    ovr_en_d    = wdat;
        3'd1:    ovr_val_d   = wdat;
        3'd2:    blink_en_d  = wdat;
        3'd3:    sticky_en_d = wdat;
        3'd4:    clr         = wdat;
        default: ;
      endcase
    end
    // a capture in the same cycle as a clear must not be lost
    sticky_d = (sticky_q & ~clr) | internal_led_i;

    rdat = '0;
    unique case (wb_adr_i[4:2])
      3'd0:    rdat = 32'(ovr_en_q);
      3'd1:    rdat = 32'(ovr_val_q);
      3'd2:    rdat = 32'(blink_en_q);
      3'd3:    rdat = 32'(sticky_en_q);
      3'd4:    rdat = 32'(eff);
      3'd5:    rdat = {16'd0, 8'(NLEDS), 8'(NPINS)};
      default: ;
    endcase
    dat_d = access ? rdat : dat_q;
    ack_d = access;
  end

  always_comb begin
    map_oe  = '0;
    map_led = '0;
    for (int a = 0; a < NPINS; a++) begin
      for (int j = 0; j < NPINS - 1; j++) begin
        if (slot_q == SW'(a * (NPINS - 1) + j)) begin
          map_oe  = NPINS'(1 << a) | NPINS'(1 << ((j < a) ? j : j + 1));
          map_led = NPINS'(1 << a);
        end
      end
    end
  end

  always_comb begin
    blink_d    = blink_q + BLINK_BITS'(1);
    dwell_last = (dwell_q == DW'(DWELL - 1));
    dwell_d    = dwell_last ? '0 : dwell_q + DW'(1);
    slot_d     = slot_q;
    if (dwell_last)
      slot_d = (slot_q == SW'(NLEDS - 1)) ? '0 : slot_q + SW'(1);
    hold_d = dwell_last ? disp[slot_d] : hold_q;
    // first cycle of every slot is blank: break-before-make
    oe_d  = '0;
    led_d = '0;
    if (dwell_q != '0 && hold_q) begin
      oe_d  = map_oe;
      led_d = map_led;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovr_en_q    <= '0;
      ovr_val_q   <= '0;
      blink_en_q  <= '0;
      sticky_en_q <= '0;
      sticky_q    <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      blink_q     <= '0;
      dwell_q     <= '0;
      slot_q      <= '0;
      hold_q      <= 1'b0;
      led_q       <= '0;
      oe_q        <= '0;
    end else begin
      ovr_en_q    <= ovr_en_d;
      ovr_val_q   <= ovr_val_d;
      blink_en_q  <= blink_en_d;
      sticky_en_q <= sticky_en_d;
      sticky_q    <= sticky_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      blink_q     <= blink_d;
      dwell_q     <= dwell_d;
      slot_q      <= slot_d;
      hold_q      <= hold_d;
      led_q       <= led_d;
      oe_q        <= oe_d;
    end
  end

  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_dat_o = dat_q;
  assign led_o    = led_q;
  assign led_oe_o = oe_q;
endmodule

// File: tb/tb_surf_led_charlieplex.sv
// Bench for surf_led_charlieplex: NPINS=4, DWELL=16, BLINK_BITS=10.
// Wishbone reads and pin windows are checked by queue-fed monitors.
module tb_surf_led_charlieplex;
  localparam int NP = 4;
  localparam int NL = 12;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic [4:0]    wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [NL-1:0] internal_led_i = '0;
  logic [NP-1:0] led_o;
  logic [NP-1:0] led_oe_o;

  surf_led_charlieplex #(
    .NPINS(4), .DWELL(16), .BLINK_BITS(10)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .internal_led_i(internal_led_i),
    .led_o(led_o), .led_oe_o(led_oe_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] dat;
  } rd_t;
  rd_t rd_q[$];
  rd_t r;
  int  acks = 0;

  always @(negedge clk) begin
    if (wb_ack_o) begin
      acks++;
      if (!wb_we_i) begin
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray read ack: got 0x%0h expected none", wb_dat_o);
        end else begin
          r = rd_q.pop_front();
          chk(r.name, wb_dat_o, r.dat);
        end
      end
    end
  end

  typedef struct {
    string      name;
    logic [3:0] oe;
    logic [3:0] led;
    int         lit;
    int         run;
    int         win;
  } pe_t;
  pe_t pin_q[$];
  pe_t p;
  int  pin_pending = 0;

  initial begin
    int lit, bad, run, maxrun;
    bit seen_blank;
    forever begin
      wait (pin_pending > 0);
      p = pin_q.pop_front();
      lit = 0; bad = 0; run = 0; maxrun = 0; seen_blank = 0;
      repeat (p.win) begin
        @(negedge clk);
        if (led_oe_o != '0) begin
          lit++;
          run++;
          if (led_oe_o !== p.oe || led_o !== p.led) bad++;
        end else begin
          if (led_o !== '0) bad++;
          if (seen_blank && run > maxrun) maxrun = run;
          run = 0;
          seen_blank = 1;
        end
      end
      chk({p.name, " lit cycles"}, lit, p.lit);
      chk({p.name, " bad pin cycles"}, bad, 0);
      chk({p.name, " run length"}, maxrun, p.run);
      pin_pending--;
    end
  end

  task automatic pins(input string nm, input logic [3:0] oe,
                      input logic [3:0] led, input int lit,
                      input int run, input int win, input int pre);
    repeat (pre) @(negedge clk);
    pin_q.push_back('{nm, oe, led, lit, run, win});
    pin_pending++;
    wait (pin_pending == 0);
  endtask

  task automatic wb(input logic we, input logic [4:0] adr,
                    input logic [31:0] d, input string nm,
                    input logic [NL-1:0] pulse);
    int lat;
    int a0;
    @(negedge clk);
    if (!we) rd_q.push_back('{nm, d});
    a0 = acks;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = we ? d : 32'h0;
    internal_led_i = internal_led_i | pulse;
    lat = 0;
    repeat (4) begin
      @(negedge clk);
      lat++;
      internal_led_i = internal_led_i & ~pulse;
      if (wb_ack_o) break;
    end
    #2;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    chk({nm, " ack latency"}, lat, 1);
    @(negedge clk);
    chk({nm, " ack count"}, acks - a0, 1);
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] d,
                    input string nm);
    wb(1'b1, adr, d, nm, '0);
  endtask

  task automatic rd(input logic [4:0] adr, input logic [31:0] exp,
                    input string nm);
    wb(1'b0, adr, exp, nm, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("oe in reset", led_oe_o, 0);
    chk("ack in reset", wb_ack_o, 0);
    #2 rst_i = 1'b1;

    pins("idle", 4'b0000, 4'b0000, 0, 0, 384, 0);
    rd(5'h14, 32'h0000_0C04, "CONFIG");

    internal_led_i = 12'h001;
    pins("led0", 4'b0011, 4'b0001, 30, 15, 384, 200);

    wr(5'h00, 32'hFFFF_FFFF, "OVR_EN wr");
    rd(5'h00, 32'h0000_0FFF, "OVR_EN rd");
    wr(5'h04, 32'h0000_0800, "OVR_VAL wr");
    internal_led_i = 12'hFFF;
    pins("led11", 4'b1100, 4'b1000, 30, 15, 384, 200);
    rd(5'h10, 32'h0000_0800, "STATE ovr");

    wr(5'h04, 32'h0000_0010, "OVR_VAL wr4");
    pins("led4", 4'b0110, 4'b0010, 30, 15, 384, 200);

    wr(5'h18, 32'hFFFF_FFFF, "unmapped wr");
    rd(5'h18, 32'h0, "unmapped rd18");
    rd(5'h1C, 32'h0, "unmapped rd1c");
    rd(5'h04, 32'h0000_0010, "OVR_VAL rd");

    wr(5'h04, 32'h0000_0008, "OVR_VAL wr3");
    wr(5'h08, 32'h0000_0008, "BLINK_EN wr");
    rd(5'h08, 32'h0000_0008, "BLINK_EN rd");
    pins("blink", 4'b0011, 4'b0010, 120, 15, 3072, 200);
    wr(5'h08, 32'h0, "BLINK_EN off");
    pins("noblink", 4'b0011, 4'b0010, 30, 15, 384, 200);

    internal_led_i = '0;
    wr(5'h00, 32'h0, "OVR_EN clr");
    wr(5'h0C, 32'h0000_0020, "STICKY_EN wr");
    wr(5'h10, 32'h0000_0FFF, "STATE clr all");
    rd(5'h10, 32'h0, "STATE cleared");
    @(negedge clk) internal_led_i = 12'h020;
    @(negedge clk) internal_led_i = '0;
    repeat (50) @(negedge clk);
    rd(5'h10, 32'h0000_0020, "STATE sticky");
    pins("sticky5", 4'b1010, 4'b0010, 30, 15, 384, 200);
    rd(5'h10, 32'h0000_0020, "STATE sticky held");
    wr(5'h10, 32'h0000_0020, "STATE clr5");
    rd(5'h10, 32'h0, "STATE after clr");
    wb(1'b1, 5'h10, 32'h0000_0020, "STATE clr+set", 12'h020);
    rd(5'h10, 32'h0000_0020, "STATE set wins");

    wr(5'h10, 32'h0000_0020, "STATE clr5b");
    internal_led_i = 12'h001;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led_oe_o == '0 && n < 400);
    chk("lit before reset", led_oe_o, 4'b0011);
    repeat (6) @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    chk("async oe clear", led_oe_o, 0);
    chk("async led clear", led_o, 0);
    repeat (2) @(negedge clk);
    #2 rst_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led_oe_o == '0 && n < 400);
    chk("restart latency", n, 194);
    chk("restart pattern", led_oe_o, 4'b0011);
    internal_led_i = '0;
    rd(5'h00, 32'h0, "OVR_EN post");
    rd(5'h04, 32'h0, "OVR_VAL post");
    rd(5'h08, 32'h0, "BLINK_EN post");
    rd(5'h0C, 32'h0, "STICKY_EN post");
    rd(5'h10, 32'h0, "STATE post");
    rd(5'h14, 32'h0000_0C04, "CONFIG post");

    repeat (4) @(negedge clk);
    if (rd_q.size() != 0) chk("reads left", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
